// File: rtl/cordic_rotation_stage.sv
// One micro-rotation of a rotation-mode CORDIC: rotates (x,y) by +/-atan(2^-shift)
// toward zero residual phase, with a single output register stage.
module cordic_rotation_stage #(
   parameter int bitwidth = 16,
   parameter int zwidth   = 16,
   parameter int shift    = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [bitwidth-1:0] xi,
   input  logic signed [bitwidth-1:0] yi,
   input  logic signed [zwidth-1:0]   zi,
   input  logic signed [zwidth-1:0]   constant,
   output logic signed [bitwidth-1:0] xo,
   output logic signed [bitwidth-1:0] yo,
   output logic signed [zwidth-1:0]   zo
);

   // Shifts of bitwidth or more collapse to pure sign fill (0 or -1).
   function automatic logic signed [bitwidth-1:0] asr(input logic signed [bitwidth-1:0] v);
      if (shift >= bitwidth)
         return {bitwidth{v[bitwidth-1]}};
      else
         return v >>> shift;
   endfunction

   logic                       z_is_pos;
   logic signed [bitwidth-1:0] xs;
   logic signed [bitwidth-1:0] ys;
   logic signed [bitwidth-1:0] x_next;
   logic signed [bitwidth-1:0] y_next;
   logic signed [zwidth-1:0]   z_next;

   logic signed [bitwidth-1:0] x_p1;
   logic signed [bitwidth-1:0] y_p1;
   logic signed [zwidth-1:0]   z_p1;

   always_comb begin
      z_is_pos = ~zi[zwidth-1];
      xs       = asr(xi);
      ys       = asr(yi);
      if (z_is_pos) begin
         x_next = xi - ys;
         y_next = yi + xs;
         z_next = zi - constant;
      end else begin
         x_next = xi + ys;
         y_next = yi - xs;
         z_next = zi + constant;
      end
   end

   // Stage p1: output registers; reset clears data so an in-flight sample is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_p1 <= '0;
         y_p1 <= '0;
         z_p1 <= '0;
      end else begin
         x_p1 <= x_next;
         y_p1 <= y_next;
         z_p1 <= z_next;
      end
   end

   assign xo = x_p1;
   assign yo = y_p1;
   assign zo = z_p1;

endmodule

// File: tb/tb_cordic_rotation_stage.sv
// Bench for cordic_rotation_stage: four instances (shift 0,1,2,20) at 18/15 bits
// checked against an integer floor-division reference model.
module tb_cordic_rotation_stage;

   localparam int BW = 18;
   localparam int ZW = 15;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic signed [BW-1:0] xi = '0;
   logic signed [BW-1:0] yi = '0;
   logic signed [ZW-1:0] zi = '0;
   logic signed [ZW-1:0] cst = '0;

   logic signed [BW-1:0] xo_s [4];
   logic signed [BW-1:0] yo_s [4];
   logic signed [ZW-1:0] zo_s [4];

   int shifts [4] = '{0, 1, 2, 20};
   int errors = 0;
   int checks = 0;
   longint px, py, pz, pc;

   always #5 clk = ~clk;

   cordic_rotation_stage #(.bitwidth(BW), .zwidth(ZW), .shift(0)) u_s0 (
      .clk(clk), .reset(reset), .xi(xi), .yi(yi), .zi(zi), .constant(cst),
      .xo(xo_s[0]), .yo(yo_s[0]), .zo(zo_s[0]));
   cordic_rotation_stage #(.bitwidth(BW), .zwidth(ZW), .shift(1)) u_s1 (
      .clk(clk), .reset(reset), .xi(xi), .yi(yi), .zi(zi), .constant(cst),
      .xo(xo_s[1]), .yo(yo_s[1]), .zo(zo_s[1]));
   cordic_rotation_stage #(.bitwidth(BW), .zwidth(ZW), .shift(2)) u_s2 (
      .clk(clk), .reset(reset), .xi(xi), .yi(yi), .zi(zi), .constant(cst),
      .xo(xo_s[2]), .yo(yo_s[2]), .zo(zo_s[2]));
   cordic_rotation_stage #(.bitwidth(BW), .zwidth(ZW), .shift(20)) u_s20 (
      .clk(clk), .reset(reset), .xi(xi), .yi(yi), .zi(zi), .constant(cst),
      .xo(xo_s[3]), .yo(yo_s[3]), .zo(zo_s[3]));

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint wrap(input longint v, input int w);
      longint m;
      m = longint'(1) << w;
      v = v % m;
      if (v < 0) v += m;
      if (v >= m / 2) v -= m;
      return v;
   endfunction

   function automatic longint floor_div2(input longint a, input int s);
      longint d, q;
      d = longint'(1) << s;
      q = a / d;
      if (a < 0 && q * d != a) q -= 1;
      return q;
   endfunction

   task automatic model(input int s, input longint x, input longint y, input longint z,
                        input longint c, output longint ex, output longint ey, output longint ez);
      longint xs, ys;
      xs = floor_div2(x, s);
      ys = floor_div2(y, s);
      if (z >= 0) begin
         ex = wrap(x - ys, BW); ey = wrap(y + xs, BW); ez = wrap(z - c, ZW);
      end else begin
         ex = wrap(x + ys, BW); ey = wrap(y - xs, BW); ez = wrap(z + c, ZW);
      end
   endtask

   task automatic drive(input longint x, input longint y, input longint z, input longint c);
      xi = BW'(x); yi = BW'(y); zi = ZW'(z); cst = ZW'(c);
      px = longint'(xi); py = longint'(yi); pz = longint'(zi); pc = longint'(cst);
   endtask

   task automatic check_all(input string tag);
      longint ex, ey, ez;
      for (int k = 0; k < 4; k++) begin
         model(shifts[k], px, py, pz, pc, ex, ey, ez);
         check($sformatf("%s_s%0d_x", tag, shifts[k]), longint'(xo_s[k]), ex);
         check($sformatf("%s_s%0d_y", tag, shifts[k]), longint'(yo_s[k]), ey);
         check($sformatf("%s_s%0d_z", tag, shifts[k]), longint'(zo_s[k]), ez);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_s%0d_x", tag, shifts[k]), longint'(xo_s[k]), 0);
         check($sformatf("%s_s%0d_y", tag, shifts[k]), longint'(yo_s[k]), 0);
         check($sformatf("%s_s%0d_z", tag, shifts[k]), longint'(zo_s[k]), 0);
      end
   endtask

   task automatic step(input longint x, input longint y, input longint z, input longint c);
      @(negedge clk);
      drive(x, y, z, c);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(123, -77, 300, 999);
      #1;
      check_zero("rst_init");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all("rst_first");

      // Async reset between edges with nonzero inputs held.
      step(5000, -3000, 700, 1234);
      check_all("pre_rst");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero("rst_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check_all("rst_release");

      step(1000, 0, 100, 8192);
      check("pos_x", longint'(xo_s[0]), 1000);
      check("pos_y", longint'(yo_s[0]), 1000);
      check("pos_z", longint'(zo_s[0]), -8092);
      check_all("pos");

      step(-8, 4, -50, 2555);
      check("neg_x", longint'(xo_s[2]), -7);
      check("neg_y", longint'(yo_s[2]), 6);
      check("neg_z", longint'(zo_s[2]), 2505);
      check_all("neg");

      step(10, -6, 0, 4836);
      check("zero_x", longint'(xo_s[1]), 13);
      check("zero_y", longint'(yo_s[1]), -1);
      check("zero_z", longint'(zo_s[1]), -4836);
      check_all("zero");

      step(131071, -1, 0, 0);
      check("wrap_x", longint'(xo_s[0]), -131072);
      check("wrap_y", longint'(yo_s[0]), 131070);
      check("wrap_z", longint'(zo_s[0]), 0);
      check_all("wrap");

      // xs = ys = -1 once the shift exceeds the width: yo = -3 + (-1).
      step(-5, -3, 1, 1);
      check("big_x", longint'(xo_s[3]), -4);
      check("big_y", longint'(yo_s[3]), -4);
      check("big_z", longint'(zo_s[3]), 0);
      check_all("big");

      // Back-to-back random vectors: each output reflects the previous cycle's inputs.
      @(negedge clk);
      drive(longint'($signed(BW'($urandom))), longint'($signed(BW'($urandom))),
            longint'($signed(ZW'($urandom))), longint'($signed(ZW'($urandom))));
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check_all("stream");
         drive(longint'($signed(BW'($urandom))), longint'($signed(BW'($urandom))),
               longint'($signed(ZW'($urandom))), longint'($signed(ZW'($urandom))));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
